// File: rtl/if_fetch_stage.sv
// if_fetch_stage: pairs each pre-IF PC with its one-cycle-late inst-SRAM word and
// hands {pc, inst, adef} to ID through a main slot backed by a skid slot.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pfs_valid,
    input  logic [31:0] pfs_pc,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken_cancel,
    input  logic        ds_allowin,
    output logic        fs_stall,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_excp_adef,
    output logic        fs_overflow
);
    logic        m_valid_q, m_valid_d, m_ok_q, m_ok_d;
    logic        s_valid_q, s_valid_d, s_ok_q, s_ok_d;
    logic [31:0] m_pc_q, m_pc_d, m_inst_q, m_inst_d;
    logic [31:0] s_pc_q, s_pc_d, s_inst_q, s_inst_d;
    logic        overflow_q, overflow_d;
    logic        fire, m_free;

    assign fs_to_ds_valid = m_valid_q & ~br_taken_cancel;
    assign fs_pc          = m_pc_q;
    assign fs_inst        = m_ok_q ? m_inst_q : inst_sram_rdata;
    assign fs_excp_adef   = m_valid_q & (m_pc_q[1:0] != 2'b00);
    assign fs_stall       = s_valid_q | (m_valid_q & ~ds_allowin);
    assign fs_overflow    = overflow_q;
    assign fire           = fs_to_ds_valid & ds_allowin;
    assign m_free         = ~m_valid_q | fire;

    always_comb begin
        // live rdata always belongs to the single slot still waiting for its word
        m_valid_d  = m_valid_q;
        m_pc_d     = m_pc_q;
        m_inst_d   = (m_valid_q & ~m_ok_q) ? inst_sram_rdata : m_inst_q;
        m_ok_d     = m_ok_q | m_valid_q;
        s_valid_d  = s_valid_q;
        s_pc_d     = s_pc_q;
        s_inst_d   = (s_valid_q & ~s_ok_q) ? inst_sram_rdata : s_inst_q;
        s_ok_d     = s_ok_q | s_valid_q;
        overflow_d = overflow_q;
        if (br_taken_cancel) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free & s_valid_q) begin
            m_valid_d = 1'b1;
            m_pc_d    = s_pc_q;
            m_inst_d  = s_ok_q ? s_inst_q : inst_sram_rdata;
            m_ok_d    = 1'b1;
            s_valid_d = pfs_valid;
            if (pfs_valid) begin
                s_pc_d = pfs_pc;
                s_ok_d = 1'b0;
            end
        end else if (m_free) begin
            m_valid_d = pfs_valid;
            if (pfs_valid) begin
                m_pc_d = pfs_pc;
                m_ok_d = 1'b0;
            end
        end else if (pfs_valid & ~s_valid_q) begin
            s_valid_d = 1'b1;
            s_pc_d    = pfs_pc;
            s_ok_d    = 1'b0;
        end else if (pfs_valid) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            m_pc_q     <= RESET_PC;
            m_inst_q   <= 32'h0;
            m_ok_q     <= 1'b0;
            s_valid_q  <= 1'b0;
            s_pc_q     <= 32'h0;
            s_inst_q   <= 32'h0;
            s_ok_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_pc_q     <= m_pc_d;
            m_inst_q   <= m_inst_d;
            m_ok_q     <= m_ok_d;
            s_valid_q  <= s_valid_d;
            s_pc_q     <= s_pc_d;
            s_inst_q   <= s_inst_d;
            s_ok_q     <= s_ok_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table for the fetch-stage scenarios, then random
// traffic checked against an in-order queue model of the two-entry fetch buffer.
module tb_if_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [31:0] K      = 32'haaaa0000;

    logic        clk = 1'b0;
    logic        reset, pfs_valid, br_taken_cancel, ds_allowin;
    logic [31:0] pfs_pc, inst_sram_rdata;
    logic        fs_stall, fs_to_ds_valid, fs_excp_adef, fs_overflow;
    logic [31:0] fs_pc, fs_inst;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_addr = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          ok;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_last_pc = RST_PC;
    bit          m_ovf = 1'b0;

    typedef struct {
        logic        rs, pv, br, al, chk;
        logic [31:0] pc;
        logic        ev, es, ea, eo;
        logic [31:0] epc, einst;
    } vec_t;
    vec_t tbl[$];

    if_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .pfs_valid(pfs_valid), .pfs_pc(pfs_pc),
        .inst_sram_rdata(inst_sram_rdata), .br_taken_cancel(br_taken_cancel),
        .ds_allowin(ds_allowin), .fs_stall(fs_stall), .fs_to_ds_valid(fs_to_ds_valid),
        .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_excp_adef(fs_excp_adef),
        .fs_overflow(fs_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rs, pv, input logic [31:0] pc, input logic br, al,
                                input logic c, ev, input logic [31:0] epc, einst,
                                input logic es, ea, eo);
        vec_t v;
        v.rs = rs; v.pv = pv; v.pc = pc; v.br = br; v.al = al; v.chk = c;
        v.ev = ev; v.epc = epc; v.einst = einst; v.es = es; v.ea = ea; v.eo = eo;
        return v;
    endfunction

    task automatic drive(input logic rs, pv, input logic [31:0] pc, input logic br, al);
        reset = rs; pfs_valid = pv; pfs_pc = pc; br_taken_cancel = br; ds_allowin = al;
        inst_sram_rdata = prev_addr ^ K;
    endtask

    task automatic model_update();
        bit fire;
        fire = (mq.size() > 0) && !br_taken_cancel && ds_allowin;
        if (reset) begin
            mq.delete();
            m_last_pc = RST_PC;
            m_ovf = 1'b0;
        end else if (br_taken_cancel) begin
            mq.delete();
        end else begin
            foreach (mq[i]) if (!mq[i].ok) begin
                mq[i].inst = inst_sram_rdata;
                mq[i].ok = 1'b1;
            end
            if (fire) void'(mq.pop_front());
            if (pfs_valid) begin
                if (mq.size() < 2) mq.push_back('{pfs_pc, 32'h0, 1'b0});
                else m_ovf = 1'b1;
            end
        end
        if (mq.size() > 0) m_last_pc = mq[0].pc;
    endtask

    task automatic model_check();
        bit mv;
        mv = mq.size() > 0;
        chk("valid", {31'b0, fs_to_ds_valid}, {31'b0, mv && !br_taken_cancel});
        chk("stall", {31'b0, fs_stall}, {31'b0, (mq.size() == 2) || (mv && !ds_allowin)});
        chk("pc", fs_pc, m_last_pc);
        chk("overflow", {31'b0, fs_overflow}, {31'b0, m_ovf});
        chk("adef", {31'b0, fs_excp_adef}, {31'b0, mv && (m_last_pc[1:0] != 2'b00)});
        if (mv) chk("inst", fs_inst, mq[0].ok ? mq[0].inst : inst_sram_rdata);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_update();
        prev_addr = pfs_pc;
        #1;
    endtask

    initial begin
        // streaming, backpressure, cancel, misaligned, overflow, reset mid-operation
        tbl.push_back(mk(1,0,32'h0,0,1, 0, 0,32'h0,32'h0,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000000,0,1, 1, 0,32'h1c000000,32'h0,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000004,0,1, 1, 1,32'h1c000000,32'hb6aa0000,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000008,0,0, 1, 1,32'h1c000004,32'hb6aa0004,1,0,0));
        tbl.push_back(mk(0,0,32'h1c000008,0,0, 1, 1,32'h1c000004,32'hb6aa0004,1,0,0));
        tbl.push_back(mk(0,0,32'h1c000008,0,0, 1, 1,32'h1c000004,32'hb6aa0004,1,0,0));
        tbl.push_back(mk(0,0,32'h1c000008,0,1, 1, 1,32'h1c000004,32'hb6aa0004,1,0,0));
        tbl.push_back(mk(0,1,32'h1c00000c,0,1, 1, 1,32'h1c000008,32'hb6aa0008,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000010,0,0, 1, 1,32'h1c00000c,32'hb6aa000c,1,0,0));
        tbl.push_back(mk(0,1,32'h1c000014,1,1, 1, 0,32'h1c00000c,32'h0,1,0,0));
        tbl.push_back(mk(0,1,32'h1c000100,0,1, 1, 0,32'h1c00000c,32'h0,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000002,0,1, 1, 1,32'h1c000100,32'hb6aa0100,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000104,0,1, 1, 1,32'h1c000002,32'hb6aa0002,0,1,0));
        tbl.push_back(mk(0,0,32'h1c000104,0,1, 1, 1,32'h1c000104,32'hb6aa0104,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000200,0,0, 1, 0,32'h1c000104,32'h0,0,0,0));
        tbl.push_back(mk(0,1,32'h1c000204,0,0, 1, 1,32'h1c000200,32'hb6aa0200,1,0,0));
        tbl.push_back(mk(0,1,32'h1c000208,0,0, 1, 1,32'h1c000200,32'hb6aa0200,1,0,0));
        tbl.push_back(mk(0,0,32'h1c000208,0,0, 1, 1,32'h1c000200,32'hb6aa0200,1,0,1));
        tbl.push_back(mk(0,0,32'h1c000208,0,1, 1, 1,32'h1c000200,32'hb6aa0200,1,0,1));
        tbl.push_back(mk(0,0,32'h1c000208,0,1, 1, 1,32'h1c000204,32'hb6aa0204,0,0,1));
        tbl.push_back(mk(0,0,32'h1c000208,0,1, 1, 0,32'h1c000204,32'h0,0,0,1));
        tbl.push_back(mk(0,1,32'h1c000300,0,0, 1, 0,32'h1c000204,32'h0,0,0,1));
        tbl.push_back(mk(0,1,32'h1c000304,0,0, 1, 1,32'h1c000300,32'hb6aa0300,1,0,1));
        tbl.push_back(mk(1,1,32'h1c000308,0,0, 1, 1,32'h1c000300,32'hb6aa0300,1,0,1));
        tbl.push_back(mk(0,0,32'h0,0,1, 1, 0,32'h1c000000,32'h0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rs, tbl[i].pv, tbl[i].pc, tbl[i].br, tbl[i].al);
            @(negedge clk);
            if (tbl[i].chk) begin
                chk($sformatf("v%0d.valid", i), {31'b0, fs_to_ds_valid}, {31'b0, tbl[i].ev});
                chk($sformatf("v%0d.pc", i), fs_pc, tbl[i].epc);
                chk($sformatf("v%0d.stall", i), {31'b0, fs_stall}, {31'b0, tbl[i].es});
                chk($sformatf("v%0d.adef", i), {31'b0, fs_excp_adef}, {31'b0, tbl[i].ea});
                chk($sformatf("v%0d.ovf", i), {31'b0, fs_overflow}, {31'b0, tbl[i].eo});
                if (tbl[i].ev) chk($sformatf("v%0d.inst", i), fs_inst, tbl[i].einst);
            end
            end_cycle();
        end

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = ($urandom & 32'hfffffffc) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, pc,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            @(negedge clk);
            if (!reset) model_check();
            end_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch (IF) stage. Receiver for the PC/valid stream from the pre-IF stage and for the matching synchronous inst-SRAM read data.
- Pairs each fetched PC with its instruction word, which returns one cycle later, and presents {pc, inst, adef} to ID with a valid/allowin handshake.
- Holds a 2-entry buffer (main + skid) so that a PC presented while IF is blocked is never lost.
- Drives the stall input back to pre-IF and flushes on branch cancel.

Parameters:
- RESET_PC, 32'h1c000000, reset value of the fs_pc register (debug visibility only).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- pfs_valid  in  1  pre-IF holds a valid PC this cycle.
- pfs_pc  in  32  PC from pre-IF; equals the inst-SRAM address this cycle.
- inst_sram_rdata  in  32  SRAM read data for the address presented in the previous cycle.
- br_taken_cancel  in  1  branch redirect from EX; flush IF.
- ds_allowin  in  1  ID can accept this cycle.
- fs_stall  out  1  to pre-IF stall input; hold PC.
- fs_to_ds_valid  out  1  instruction valid to ID.
- fs_pc  out  32  PC of the instruction presented to ID.
- fs_inst  out  32  instruction presented to ID.
- fs_excp_adef  out  1  fs_pc[1:0] != 0 (fetch address misaligned).
- fs_overflow  out  1  sticky error: a valid PC was dropped.

Behaviour:
- Storage: two slots, M (main) and S (skid). Each slot has valid, pc[31:0], inst[31:0], inst_ok.
- Slot load: a slot loads pc with inst_ok=0. On the next edge it captures inst<=inst_sram_rdata and inst_ok<=1.
  - At most one slot can have inst_ok=0 in any cycle, because at most one load occurs per cycle.
- Combinational outputs:
  - fs_to_ds_valid = M.valid & ~br_taken_cancel.
  - fs_pc = M.pc.
  - fs_inst = M.inst_ok ? M.inst : inst_sram_rdata.
  - fs_excp_adef = M.valid & (M.pc[1:0] != 0).
  - fs_stall = S.valid | (M.valid & ~ds_allowin).
- Handshake:
  - fire = fs_to_ds_valid & ds_allowin.
  - m_free = ~M.valid | fire.
- Priority each cycle (first match wins):
  1. reset: M.valid=S.valid=0, inst_ok=0, M.pc=RESET_PC, fs_overflow=0.
  2. br_taken_cancel: M.valid=S.valid=0. pfs_valid is ignored this cycle, because its PC is the wrong path; pre-IF loads br_target this edge. fs_overflow is unchanged.
  3. m_free & S.valid: S moves to M, including inst_ok and inst.
     - If S.inst_ok=0, the rdata capture lands in M.inst, and M.inst_ok=1.
     - If pfs_valid is also set, load the PC into S.
  4. m_free & ~S.valid & pfs_valid: load M.
  5. ~m_free & pfs_valid & ~S.valid: load S.
  6. ~m_free & pfs_valid & S.valid: drop the PC and set fs_overflow<=1 (sticky until reset).
- Otherwise, a slot whose inst_ok=0 still performs its rdata capture.
- Latency: a PC valid at pre-IF in cycle N appears on fs_to_ds_valid in cycle N+1, with fs_inst = live rdata. Its earliest transfer to ID is cycle N+1.
- Stall interplay:
  - Pre-IF holds its PC and deasserts pfs_valid the cycle after fs_stall.
  - The PC valid in the first stall cycle is caught in S.
  - While stalled, pre-IF keeps the SRAM address constant, so S's rdata capture is correct.
- Cancel with a concurrent ID handshake: fs_to_ds_valid is forced to 0, so no transfer occurs.
- Reset mid-operation: all state clears in one edge, with no partial capture.
- No combinational path from pfs_valid to fs_stall.

Test Plan:
- Streaming:
  - Stimulus: reset, then pfs_valid=1 with PCs 0x1c000000, +4, +8; ds_allowin=1; rdata = PC^0xAAAA0000 one cycle after each PC.
  - Required: fs_to_ds_valid=1 from cycle 2 onward; each (fs_pc, fs_inst) pair matches; fs_stall=0 throughout.
- Backpressure:
  - Stimulus: ds_allowin=0 for 3 cycles while M holds 0x1c000004.
  - Required: fs_stall=1; S captures 0x1c000008 and its data; fs_inst stays 0x1c000004's word (buffered, not live rdata).
  - On release: 0x1c000004 then 0x1c000008 transfer in consecutive cycles with no loss or duplication.
- Branch cancel:
  - Stimulus: br_taken_cancel=1 with M and S full, pfs_valid=1, ds_allowin=1.
  - Required: fs_to_ds_valid=0 that cycle; both slots empty next cycle; the next pfs_pc=br_target (0x1c000100) is output one cycle later with correct data.
- Misaligned PC:
  - Stimulus: pfs_pc=0x1c000002.
  - Required: fs_excp_adef=1 while that entry is in M; 0 for aligned entries.
- Overflow:
  - Stimulus: force pfs_valid=1 for 3 cycles with ds_allowin=0 and fs_stall ignored.
  - Required: third PC dropped; fs_overflow=1, which stays set until reset.
- Reset mid-operation:
  - Stimulus: assert reset with both slots full.
  - Required: next cycle fs_to_ds_valid=0, fs_stall=0, fs_pc=0x1c000000, fs_overflow=0.
